// File: rtl/sm_hex_scan_pkg.sv
// Shared definitions for the multiplexed hex display: segment font, blank code
// and the scan control states.
package sm_hex_scan_pkg;

    // Active-high segment codes, {g,f,e,d,c,b,a}
    localparam logic [6:0] SM_SEG_OFF = 7'h00;
    localparam logic [6:0] SM_SEG_0   = 7'h3F;
    localparam logic [6:0] SM_SEG_1   = 7'h06;
    localparam logic [6:0] SM_SEG_2   = 7'h5B;
    localparam logic [6:0] SM_SEG_3   = 7'h4F;
    localparam logic [6:0] SM_SEG_4   = 7'h66;
    localparam logic [6:0] SM_SEG_5   = 7'h6D;
    localparam logic [6:0] SM_SEG_6   = 7'h7D;
    localparam logic [6:0] SM_SEG_7   = 7'h07;
    localparam logic [6:0] SM_SEG_8   = 7'h7F;
    localparam logic [6:0] SM_SEG_9   = 7'h6F;
    localparam logic [6:0] SM_SEG_A   = 7'h77;
    localparam logic [6:0] SM_SEG_B   = 7'h7C;
    localparam logic [6:0] SM_SEG_C   = 7'h39;
    localparam logic [6:0] SM_SEG_D   = 7'h5E;
    localparam logic [6:0] SM_SEG_E   = 7'h79;
    localparam logic [6:0] SM_SEG_F   = 7'h71;

    typedef enum logic {
        SCAN_PRIME,
        SCAN_RUN
    } scan_state_t;

endpackage

// File: rtl/sm_hex_scan_if.sv
// Display-side signal bundle: the controlling logic is master, the scanner is slave.
interface sm_hex_scan_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  enable;
    logic                  blank_lz;
    logic [4*DIGITS-1:0]   number;
    logic [DIGITS-1:0]     dots;
    logic [6:0]            seven_segments;
    logic                  dot;
    logic [DIGITS-1:0]     anodes;
    logic                  frame_tick;

    modport master (
        output enable, blank_lz, number, dots,
        input  seven_segments, dot, anodes, frame_tick
    );

    modport slave (
        input  enable, blank_lz, number, dots,
        output seven_segments, dot, anodes, frame_tick
    );
endinterface

// File: rtl/sm_hex_to_seg.sv
// Combinational 4-bit hex to 7-segment decoder, active-high {g,f,e,d,c,b,a}.
module sm_hex_to_seg
    import sm_hex_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    always_comb begin
        seg = SM_SEG_OFF;
        case (hex)
            4'h0: seg = SM_SEG_0;
            4'h1: seg = SM_SEG_1;
            4'h2: seg = SM_SEG_2;
            4'h3: seg = SM_SEG_3;
            4'h4: seg = SM_SEG_4;
            4'h5: seg = SM_SEG_5;
            4'h6: seg = SM_SEG_6;
            4'h7: seg = SM_SEG_7;
            4'h8: seg = SM_SEG_8;
            4'h9: seg = SM_SEG_9;
            4'hA: seg = SM_SEG_A;
            4'hB: seg = SM_SEG_B;
            4'hC: seg = SM_SEG_C;
            4'hD: seg = SM_SEG_D;
            4'hE: seg = SM_SEG_E;
            4'hF: seg = SM_SEG_F;
            default: seg = SM_SEG_OFF;
        endcase
    end
endmodule

// File: rtl/sm_hex_scan.sv
// Multiplexed DIGITS-wide hex display driver with internal refresh prescaler,
// per-frame snapshot of the value and optional leading-zero blanking.
module sm_hex_scan
    import sm_hex_scan_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned PRESCALE      = 1024,
    parameter bit          ANODE_ACT_LOW = 1'b1,
    parameter bit          SEG_ACT_LOW   = 1'b1
)(
    input  logic         clk,
    input  logic         rst_n,
    sm_hex_scan_if.slave bus
);
    localparam int unsigned     PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned     IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]   PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [6:0]      SEG_INV   = {7{SEG_ACT_LOW}};
    localparam logic [DIGITS-1:0] AN_INV  = {DIGITS{ANODE_ACT_LOW}};

    scan_state_t         state_q, state_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] snap_q;
    logic [DIGITS-1:0]   dsnap_q;
    logic                take_snap;

    logic [4*DIGITS-1:0] src_num;
    logic [DIGITS-1:0]   src_dots;
    logic [DIGITS-1:0]   onehot;
    logic [DIGITS-1:0]   lz_mask;
    logic                zero_above;
    logic [3:0]          cur_nib;
    logic                cur_dot;
    logic                blank_cur;
    logic [6:0]          seg_raw;

    logic [6:0]          seg_q;
    logic                dot_q;
    logic [DIGITS-1:0]   anodes_q;
    logic                frame_tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN_PRIME;
            pcnt_q  <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            dsnap_q <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            if (take_snap) begin
                snap_q  <= bus.number;
                dsnap_q <= bus.dots;
            end
        end
    end

    // Snapshot on the first enabled cycle after reset and on every frame wrap.
    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        idx_d     = idx_q;
        take_snap = 1'b0;
        if (bus.enable) begin
            if (state_q == SCAN_PRIME) begin
                take_snap = 1'b1;
                state_d   = SCAN_RUN;
            end
            if (pcnt_q == PCNT_LAST) begin
                pcnt_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d     = '0;
                    take_snap = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end else begin
                pcnt_d = pcnt_q + PW'(1);
            end
        end
    end

    // The priming cycle displays the value being captured, so the first slot is not stale.
    always_comb begin
        src_num  = (state_q == SCAN_PRIME) ? bus.number : snap_q;
        src_dots = (state_q == SCAN_PRIME) ? bus.dots   : dsnap_q;
        cur_nib  = '0;
        cur_dot  = 1'b0;
        onehot   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = src_num[4*i +: 4];
                cur_dot   = src_dots[i];
                onehot[i] = 1'b1;
            end
        end
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            zero_above = zero_above & (src_num[4*(DIGITS-1-k) +: 4] == 4'h0);
            if (k != DIGITS - 1) begin
                lz_mask[DIGITS-1-k] = zero_above;
            end
        end
        blank_cur = bus.blank_lz & (|(lz_mask & onehot));
    end

    sm_hex_to_seg u_dec (
        .hex (cur_nib),
        .seg (seg_raw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= SM_SEG_OFF ^ SEG_INV;
            dot_q        <= SEG_ACT_LOW;
            anodes_q     <= AN_INV;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= take_snap;
            if (bus.enable) begin
                seg_q    <= (blank_cur ? SM_SEG_OFF : seg_raw) ^ SEG_INV;
                dot_q    <= cur_dot ^ SEG_ACT_LOW;
                anodes_q <= onehot ^ AN_INV;
            end else begin
                seg_q    <= SM_SEG_OFF ^ SEG_INV;
                dot_q    <= SEG_ACT_LOW;
                anodes_q <= AN_INV;
            end
        end
    end

    assign bus.seven_segments = seg_q;
    assign bus.dot            = dot_q;
    assign bus.anodes         = anodes_q;
    assign bus.frame_tick     = frame_tick_q;

endmodule

// File: tb/tb_sm_hex_scan.sv
// Bench for sm_hex_scan: directed scenarios on three parameterisations plus a
// randomized run against a count-based reference model of the 4-digit instance.
module tb_sm_hex_scan;

    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [3:0] AN_TAB [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    sm_hex_scan_if #(.DIGITS(4)) bus_a ();
    sm_hex_scan_if #(.DIGITS(8)) bus_b ();
    sm_hex_scan_if #(.DIGITS(1)) bus_c ();

    sm_hex_scan #(.DIGITS(4), .PRESCALE(4), .ANODE_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    sm_hex_scan #(.DIGITS(8), .PRESCALE(1), .ANODE_ACT_LOW(1'b0), .SEG_ACT_LOW(1'b0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    sm_hex_scan #(.DIGITS(1), .PRESCALE(1), .ANODE_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    // Reference model for dut_a: m_cnt = enabled cycles since reset.
    int unsigned m_cnt;
    logic [15:0] m_snap;
    logic [3:0]  m_dsnap;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dot;
    logic        e_ft;

    task automatic model_step();
        int unsigned slot;
        logic [15:0] src;
        logic [3:0]  sd;
        logic [3:0]  nib;
        logic        blanked;
        if (!bus_a.enable) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dot = 1'b1; e_ft = 1'b0;
        end else begin
            src     = (m_cnt == 0) ? bus_a.number : m_snap;
            sd      = (m_cnt == 0) ? bus_a.dots : m_dsnap;
            slot    = (m_cnt / 4) % 4;
            nib     = 4'(src >> (4 * slot));
            blanked = bus_a.blank_lz && (slot != 0) && ((src >> (4 * slot)) == 16'h0);
            e_an    = ~(4'b0001 << slot);
            e_seg   = blanked ? 7'h7F : ~FONT[nib];
            e_dot   = ~sd[slot];
            e_ft    = (m_cnt == 0) || (((m_cnt + 1) % 16) == 0);
            if (e_ft) begin
                m_snap  = bus_a.number;
                m_dsnap = bus_a.dots;
            end
            m_cnt++;
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.enable = 1'b0; bus_a.blank_lz = 1'b0; bus_a.number = '0; bus_a.dots = '0;
        bus_b.enable = 1'b0; bus_b.blank_lz = 1'b0; bus_b.number = '0; bus_b.dots = '0;
        bus_c.enable = 1'b0; bus_c.blank_lz = 1'b0; bus_c.number = '0; bus_c.dots = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_cnt = 0; m_snap = '0; m_dsnap = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus_a.anodes, bus_a.seven_segments, bus_a.dot, bus_a.frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0})
            $display("FAIL reset_a got an=%h seg=%h dot=%b ft=%b want an=f seg=7f dot=1 ft=0",
                     bus_a.anodes, bus_a.seven_segments, bus_a.dot, bus_a.frame_tick);
        else passed++;
        checks++;
        if ({bus_b.anodes, bus_b.seven_segments, bus_b.dot, bus_b.frame_tick} !== {8'h00, 7'h00, 1'b0, 1'b0})
            $display("FAIL reset_b got an=%h seg=%h dot=%b ft=%b want an=00 seg=00 dot=0 ft=0",
                     bus_b.anodes, bus_b.seven_segments, bus_b.dot, bus_b.frame_tick);
        else passed++;
        checks++;
        if ({bus_c.anodes, bus_c.seven_segments, bus_c.dot} !== {1'b1, 7'h7F, 1'b1})
            $display("FAIL reset_c got an=%b seg=%h dot=%b want an=1 seg=7f dot=1",
                     bus_c.anodes, bus_c.seven_segments, bus_c.dot);
        else passed++;
    endtask

    task automatic test_scan();
        int slot;
        logic [3:0] dig;
        logic exp_ft;
        logic [15:0] val;
        do_reset();
        val = 16'h1234;
        bus_a.number = val; bus_a.enable = 1'b1;
        for (int k = 0; k < 32; k++) begin
            cyc();
            slot = (k / 4) % 4;
            dig  = 4'(val >> (4 * slot));
            checks++;
            if ({bus_a.anodes, bus_a.seven_segments} !== {AN_TAB[slot], ~FONT[dig]})
                $display("FAIL scan k=%0d got an=%h seg=%h want an=%h seg=%h",
                         k, bus_a.anodes, bus_a.seven_segments, AN_TAB[slot], ~FONT[dig]);
            else passed++;
            exp_ft = (k == 0) || (k == 15) || (k == 31);
            checks++;
            if (bus_a.frame_tick !== exp_ft)
                $display("FAIL scan_tick k=%0d got %b want %b", k, bus_a.frame_tick, exp_ft);
            else passed++;
        end
    endtask

    task automatic test_coherence();
        int slot;
        logic [15:0] val;
        logic [3:0] dig;
        do_reset();
        bus_a.number = 16'h1234; bus_a.enable = 1'b1;
        for (int k = 0; k < 48; k++) begin
            if (k == 22) bus_a.number = 16'hABCD;
            cyc();
            slot = (k / 4) % 4;
            val  = (k < 32) ? 16'h1234 : 16'hABCD;
            dig  = 4'(val >> (4 * slot));
            checks++;
            if ({bus_a.anodes, bus_a.seven_segments} !== {AN_TAB[slot], ~FONT[dig]})
                $display("FAIL coherence k=%0d got an=%h seg=%h want an=%h seg=%h",
                         k, bus_a.anodes, bus_a.seven_segments, AN_TAB[slot], ~FONT[dig]);
            else passed++;
        end
    endtask

    task automatic test_leading_zero();
        int slot;
        logic [15:0] val;
        logic [3:0] dv;
        logic [3:0] dig;
        logic blank;
        logic [6:0] eseg;
        do_reset();
        bus_a.number = 16'h0050; bus_a.blank_lz = 1'b1; bus_a.enable = 1'b1;
        for (int k = 0; k < 48; k++) begin
            if (k == 16) begin
                bus_a.number = 16'h0000;
                bus_a.dots   = 4'b1000;
            end
            cyc();
            slot  = (k / 4) % 4;
            val   = (k < 32) ? 16'h0050 : 16'h0000;
            dv    = (k < 32) ? 4'b0000 : 4'b1000;
            blank = (k < 32) ? (slot >= 2) : (slot >= 1);
            dig   = 4'(val >> (4 * slot));
            eseg  = blank ? 7'h7F : ~FONT[dig];
            checks++;
            if ({bus_a.anodes, bus_a.seven_segments, bus_a.dot} !== {AN_TAB[slot], eseg, ~dv[slot]})
                $display("FAIL leading_zero k=%0d got an=%h seg=%h dot=%b want an=%h seg=%h dot=%b",
                         k, bus_a.anodes, bus_a.seven_segments, bus_a.dot, AN_TAB[slot], eseg, ~dv[slot]);
            else passed++;
        end
    endtask

    task automatic test_enable();
        do_reset();
        bus_a.number = 16'h1234; bus_a.enable = 1'b1;
        repeat (9) cyc();
        bus_a.enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++;
            if ({bus_a.anodes, bus_a.seven_segments, bus_a.dot, bus_a.frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0})
                $display("FAIL enable_dark k=%0d got an=%h seg=%h dot=%b ft=%b want an=f seg=7f dot=1 ft=0",
                         k, bus_a.anodes, bus_a.seven_segments, bus_a.dot, bus_a.frame_tick);
            else passed++;
        end
        bus_a.enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++;
            if (k < 3) begin
                if ({bus_a.anodes, bus_a.seven_segments} !== {4'hB, ~FONT[2]})
                    $display("FAIL enable_resume k=%0d got an=%h seg=%h want an=b seg=%h",
                             k, bus_a.anodes, bus_a.seven_segments, ~FONT[2]);
                else passed++;
            end else begin
                if ({bus_a.anodes, bus_a.seven_segments} !== {4'h7, ~FONT[1]})
                    $display("FAIL enable_next got an=%h seg=%h want an=7 seg=%h",
                             bus_a.anodes, bus_a.seven_segments, ~FONT[1]);
                else passed++;
            end
        end
        // Drop enable exactly on the slot-wrap cycle: no advance may happen.
        do_reset();
        bus_a.number = 16'h1234; bus_a.enable = 1'b1;
        repeat (3) cyc();
        bus_a.enable = 1'b0;
        cyc();
        bus_a.enable = 1'b1;
        cyc();
        checks++;
        if (bus_a.anodes !== 4'hE)
            $display("FAIL enable_at_wrap got an=%h want an=e", bus_a.anodes);
        else passed++;
        cyc();
        checks++;
        if (bus_a.anodes !== 4'hD)
            $display("FAIL enable_after_wrap got an=%h want an=d", bus_a.anodes);
        else passed++;
    endtask

    task automatic test_reset_midscan();
        do_reset();
        bus_a.number = 16'h1234; bus_a.enable = 1'b1;
        repeat (10) cyc();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_a.anodes, bus_a.seven_segments, bus_a.dot, bus_a.frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0})
            $display("FAIL reset_midscan got an=%h seg=%h dot=%b ft=%b want an=f seg=7f dot=1 ft=0",
                     bus_a.anodes, bus_a.seven_segments, bus_a.dot, bus_a.frame_tick);
        else passed++;
        m_cnt = 0; m_snap = '0; m_dsnap = '0;
        #2;
        rst_n = 1'b1;
        cyc();
        checks++;
        if ({bus_a.anodes, bus_a.seven_segments, bus_a.frame_tick} !== {4'hE, ~FONT[4], 1'b1})
            $display("FAIL reset_release got an=%h seg=%h ft=%b want an=e seg=%h ft=1",
                     bus_a.anodes, bus_a.seven_segments, bus_a.frame_tick, ~FONT[4]);
        else passed++;
    endtask

    task automatic test_params();
        logic [31:0] num_b;
        int slot;
        logic [3:0] dig;
        logic [3:0] dig_c;
        logic [7:0] ean;
        do_reset();
        num_b = $urandom;
        bus_b.number = num_b; bus_b.dots = 8'h01; bus_b.enable = 1'b1;
        bus_c.number = 4'h7;  bus_c.dots = 1'b1;  bus_c.enable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) bus_c.number = 4'hE;
            cyc();
            slot = k % 8;
            dig  = 4'(num_b >> (4 * slot));
            ean  = 8'h01 << slot;
            checks++;
            if ({bus_b.anodes, bus_b.seven_segments, bus_b.dot} !== {ean, FONT[dig], (slot == 0)})
                $display("FAIL params_b k=%0d got an=%h seg=%h dot=%b want an=%h seg=%h dot=%b",
                         k, bus_b.anodes, bus_b.seven_segments, bus_b.dot, ean, FONT[dig], (slot == 0));
            else passed++;
            checks++;
            if (bus_b.frame_tick !== ((k == 0) || (slot == 7)))
                $display("FAIL params_b_tick k=%0d got %b want %b", k, bus_b.frame_tick, ((k == 0) || (slot == 7)));
            else passed++;
            dig_c = (k <= 8) ? 4'h7 : 4'hE;
            checks++;
            if ({bus_c.anodes, bus_c.seven_segments, bus_c.dot, bus_c.frame_tick} !== {1'b0, ~FONT[dig_c], 1'b0, 1'b1})
                $display("FAIL params_c k=%0d got an=%b seg=%h dot=%b ft=%b want an=0 seg=%h dot=0 ft=1",
                         k, bus_c.anodes, bus_c.seven_segments, bus_c.dot, bus_c.frame_tick, ~FONT[dig_c]);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [15:0] n;
        do_reset();
        bus_a.enable = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int d = 0; d < 4; d++)
                    n[4*d +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
                bus_a.number = n;
            end
            if ($urandom_range(0, 15) == 0) bus_a.blank_lz = ~bus_a.blank_lz;
            if ($urandom_range(0, 11) == 0) bus_a.dots = 4'($urandom_range(0, 15));
            bus_a.enable = ($urandom_range(0, 7) != 0);
            cyc();
            checks++;
            if ({bus_a.anodes, bus_a.seven_segments, bus_a.dot, bus_a.frame_tick} !== {e_an, e_seg, e_dot, e_ft})
                $display("FAIL random k=%0d got an=%h seg=%h dot=%b ft=%b want an=%h seg=%h dot=%b ft=%b",
                         k, bus_a.anodes, bus_a.seven_segments, bus_a.dot, bus_a.frame_tick,
                         e_an, e_seg, e_dot, e_ft);
            else passed++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        m_cnt = 0; m_snap = '0; m_dsnap = '0;
        test_reset();
        test_scan();
        test_coherence();
        test_leading_zero();
        test_enable();
        test_reset_midscan();
        test_params();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
